// File: rtl/clk_gen_ds_pkg.sv
// Shared types and helpers for the clock generator / downsampler sequencing controller.
// Pure declarations; no latency or backpressure of its own.
package clk_gen_ds_pkg;

  localparam int SEL_WIDTH  = 8;
  localparam int DS_SEL_MSB = 7;
  localparam int DS_SEL_LSB = 4;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    LOCK,
    SETTLE,
    DONE
  } ctrl_state_e;

  typedef enum logic [1:0] {
    NOOP,
    DS_ONLY,
    FULL
  } seq_kind_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Only the downsampler needs a reset when the clkgen nibble is unchanged.
  function automatic seq_kind_e classify(input logic [SEL_WIDTH-1:0] s,
                                         input logic [SEL_WIDTH-1:0] c);
    if (s == c) begin
      return NOOP;
    end else if ((s[DS_SEL_LSB-1:0] == c[DS_SEL_LSB-1:0]) &&
                 (s[DS_SEL_MSB:DS_SEL_LSB] != c[DS_SEL_MSB:DS_SEL_LSB])) begin
      return DS_ONLY;
    end else begin
      return FULL;
    end
  endfunction

endpackage

// File: rtl/clk_ctrl_timer.sv
// Loadable down-counter that stops at zero; load wins over counting, zero_o is combinational.
// No backpressure: counts every cycle it is not being loaded.
module clk_ctrl_timer #(
  parameter int               WIDTH_P = 4,
  parameter logic [WIDTH_P-1:0] INIT_P  = '0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic [WIDTH_P-1:0] load_val_i,
  output logic               zero_o
);

  logic [WIDTH_P-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt <= INIT_P;
    end else if (load_i) begin
      cnt <= load_val_i;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero_o = (cnt == '0);

endmodule

// File: rtl/clk_gen_ds_ctrl.sv
// Sequences select changes into the clkgen/downsampler pair under reset; full sequence takes R+L+D+1 cycles to done.
// Backpressure: sel_ready_o is high only in IDLE; requests offered in any other state are dropped.
module clk_gen_ds_ctrl
  import clk_gen_ds_pkg::*;
#(
  parameter int                   RESET_CYCLES_P  = 4,
  parameter int                   LOCK_CYCLES_P   = 16,
  parameter int                   SETTLE_CYCLES_P = 8,
  parameter logic [SEL_WIDTH-1:0] DEFAULT_SEL_P   = 8'h00
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 sel_v_i,
  input  logic [SEL_WIDTH-1:0] sel_i,
  output logic                 sel_ready_o,
  output logic [SEL_WIDTH-1:0] select_o,
  output logic                 clk_reset_o,
  output logic                 ds_reset_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [SEL_WIDTH-1:0] cur_sel_o
);

  localparam int CNT_MAX = max3(RESET_CYCLES_P, LOCK_CYCLES_P, SETTLE_CYCLES_P);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(RESET_CYCLES_P - 1);
  localparam logic [CNT_W-1:0] LOCK_LD   = CNT_W'(LOCK_CYCLES_P - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES_P - 1);

  ctrl_state_e          state, state_nxt;
  seq_kind_e            seq_kind, req_kind;
  logic [SEL_WIDTH-1:0] seq_sel, cur_sel;
  logic                 accept;
  logic                 tmr_load, tmr_zero;
  logic [CNT_W-1:0]     tmr_val;

  // Reset value matches the HOLD load so the boot sequence times like any full request.
  clk_ctrl_timer #(
    .WIDTH_P (CNT_W),
    .INIT_P  (HOLD_LD)
  ) u_timer (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state    <= HOLD;
      seq_kind <= FULL;
      seq_sel  <= DEFAULT_SEL_P;
      cur_sel  <= DEFAULT_SEL_P;
    end else begin
      state <= state_nxt;
      if (accept) begin
        seq_sel  <= sel_i;
        seq_kind <= req_kind;
      end
      // A no-op never leaves IDLE through the counting states, so cur_sel is already right.
      if ((state_nxt == DONE) && (state != IDLE)) begin
        cur_sel <= seq_sel;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    sel_ready_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    clk_reset_o = 1'b0;
    ds_reset_o  = 1'b0;
    select_o    = seq_sel;
    req_kind    = classify(sel_i, cur_sel);

    unique case (state)
      IDLE: begin
        busy_o      = 1'b0;
        sel_ready_o = 1'b1;
        select_o    = cur_sel;
        if (sel_v_i) begin
          accept = 1'b1;
          if (req_kind == NOOP) begin
            state_nxt = DONE;
          end else begin
            state_nxt = HOLD;
            tmr_load  = 1'b1;
            tmr_val   = HOLD_LD;
          end
        end
      end
      HOLD: begin
        ds_reset_o  = 1'b1;
        clk_reset_o = (seq_kind == FULL);
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (seq_kind == FULL) begin
            state_nxt = LOCK;
            tmr_val   = LOCK_LD;
          end else begin
            state_nxt = SETTLE;
            tmr_val   = SETTLE_LD;
          end
        end
      end
      LOCK: begin
        ds_reset_o = 1'b1;
        if (tmr_zero) begin
          state_nxt = SETTLE;
          tmr_load  = 1'b1;
          tmr_val   = SETTLE_LD;
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_o    = 1'b1;
        busy_o    = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign cur_sel_o = cur_sel;

endmodule

// File: tb/tb_clk_gen_ds_ctrl.sv
// Bench for clk_gen_ds_ctrl: directed requests, an offset-based cycle model and a done scoreboard.
module tb_clk_gen_ds_ctrl;

  localparam int R = 4;
  localparam int L = 16;
  localparam int D = 8;
  localparam logic [7:0] DEF = 8'h00;
  localparam int END_FULL = 29;
  localparam int END_DS   = 13;
  localparam int END_NOOP = 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sel_v;
  logic [7:0] sel;
  logic       sel_ready_o, clk_reset_o, ds_reset_o, busy_o, done_o;
  logic [7:0] select_o, cur_sel_o;

  always #5 clk = ~clk;

  clk_gen_ds_ctrl #(
    .RESET_CYCLES_P  (R),
    .LOCK_CYCLES_P   (L),
    .SETTLE_CYCLES_P (D),
    .DEFAULT_SEL_P   (DEF)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .sel_v_i     (sel_v),
    .sel_i       (sel),
    .sel_ready_o (sel_ready_o),
    .select_o    (select_o),
    .clk_reset_o (clk_reset_o),
    .ds_reset_o  (ds_reset_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .cur_sel_o   (cur_sel_o)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // kind: 0 no-op, 1 DS-only, 2 full
  function automatic int tb_kind(input logic [7:0] s, input logic [7:0] c);
    if (s == c) return 0;
    if (s[3:0] == c[3:0]) return 1;
    return 2;
  endfunction

  function automatic int tb_end(input int k);
    return (k == 2) ? END_FULL : (k == 1) ? END_DS : END_NOOP;
  endfunction

  // {clk_reset, ds_reset, busy, ready, done, select, cur_sel} d cycles after the start edge
  function automatic logic [20:0] exp_out(input int k, input int d,
                                          input logic [7:0] s, input logic [7:0] c);
    int  e;
    logic cr, dr;
    e = tb_end(k);
    if (d > e)  return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s, s};
    if (d == e) return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, s, s};
    cr = (k == 2) && (d <= R);
    dr = (d <= R) || ((k == 2) && (d <= R + L));
    return {cr, dr, 1'b1, 1'b0, 1'b0, s, c};
  endfunction

  typedef struct {
    logic [7:0] sel;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  bit         m_vld = 1'b0;
  int         m_t   = 0;
  int         m_kind = 2;
  logic [7:0] m_s = DEF;
  logic [7:0] m_c = DEF;

  // Reference model: tracks the start edge of the current sequence and pushes expected completions.
  always @(posedge clk) begin
    if (!reset_n) begin
      m_vld  <= 1'b1;
      m_t    <= cyc;
      m_kind <= 2;
      m_s    <= DEF;
      m_c    <= DEF;
      sb_q.delete();
      sb_q.push_back('{DEF, cyc + END_FULL});
    end else if (m_vld && ((cyc - m_t) > tb_end(m_kind)) && sel_v) begin
      m_c    <= m_s;
      m_s    <= sel;
      m_kind <= tb_kind(sel, m_s);
      m_t    <= cyc;
      sb_q.push_back('{sel, cyc + tb_end(tb_kind(sel, m_s))});
    end
  end

  // Monitor: cycle-level output check plus scoreboard pop on every done pulse.
  always @(negedge clk) begin
    if (m_vld) begin
      chk("outputs", {11'd0, clk_reset_o, ds_reset_o, busy_o, sel_ready_o, done_o, select_o, cur_sel_o},
          {11'd0, exp_out(m_kind, cyc - m_t, m_s, m_c)});
      if (done_o) begin
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          chk("done_cycle", cyc, sb_q[0].cyc);
          chk("done_sel", {24'd0, cur_sel_o}, {24'd0, sb_q[0].sel});
          void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic wait_done(input int t, input int off, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (done_o) found = 1'b1;
      else @(negedge clk);
    end
    chk({name, "_done_seen"}, 32'(found), 32'd1);
    if (found) chk({name, "_latency"}, cyc - t, off);
  endtask

  task automatic wait_ready(input string name, output int t);
    bit ok;
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (sel_ready_o) ok = 1'b1;
    end
    chk({name, "_ready"}, 32'(ok), 32'd1);
    t = cyc;
  endtask

  task automatic do_req(input logic [7:0] s, input int off, input string name);
    int t;
    wait_ready(name, t);
    sel_v = 1'b1;
    sel   = s;
    @(negedge clk);
    sel_v = 1'b0;
    wait_done(t, off, name);
  endtask

  initial begin
    int t;
    reset_n = 1'b0;
    sel_v   = 1'b0;
    sel     = 8'h00;

    // Boot sequence after reset release.
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    t = cyc - 1;
    wait_done(t, END_FULL, "boot");
    chk("boot_cur_sel", {24'd0, cur_sel_o}, 32'h00);

    do_req(8'h03, END_FULL, "full_03");
    do_req(8'h53, END_DS,   "ds_53");
    do_req(8'h53, END_NOOP, "noop_53");
    @(negedge clk);
    chk("noop_cur_sel", {24'd0, cur_sel_o}, 32'h53);

    // Requests held valid while busy: only IDLE-cycle ones are accepted.
    sel_v = 1'b1;
    for (int i = 0; i < 120; i++) begin
      sel = i[0] ? 8'h21 : 8'h10;
      @(negedge clk);
    end
    sel_v = 1'b0;

    // Reset during LOCK of a request for 8'h07.
    wait_ready("abort_07", t);
    sel_v = 1'b1;
    sel   = 8'h07;
    @(negedge clk);
    sel_v = 1'b0;
    repeat (R + 2) @(negedge clk);
    chk("abort_in_lock", {30'd0, clk_reset_o, ds_reset_o}, 32'b01);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    t = cyc - 1;
    wait_done(t, END_FULL, "reboot");
    chk("reboot_cur_sel", {24'd0, cur_sel_o}, 32'h00);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
